// File: rtl/vdp_pkg.sv
// Shared types and default timing for the VDP VRAM scheduler.
package vdp_pkg;
    typedef enum logic [1:0] {
        CODE_VRD  = 2'd0,
        CODE_VWR  = 2'd1,
        CODE_REG  = 2'd2,
        CODE_CRAM = 2'd3
    } code_e;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_RD   = 2'd1,
        P_WR   = 2'd2
    } pend_e;

    localparam int SLOT_LEN_DEF = 8;
    localparam int RD_LAT_DEF   = 3;
endpackage

// File: rtl/vdp_slot_timer.sv
// Free-running VRAM slot counter: flags slot cycle 0 and the I/O read-capture cycle.
module vdp_slot_timer
    import vdp_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic slot_start_o,
    output logic rd_cap_o
);
    localparam int CW = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(SLOT_LEN - 1)) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Gated with reset so every output reads 0 while reset is held.
    assign slot_start_o = !rst_i && (cnt_q == '0);
    assign rd_cap_o     = !rst_i && (cnt_q == CW'(RD_LAT));
endmodule

// File: rtl/vdp_vram_sched.sv
// VDP CPU port controller: address/code register, read-ahead buffer and slotted VRAM I/O access.
module vdp_vram_sched
    import vdp_pkg::*;
#(
    parameter int SLOT_LEN = SLOT_LEN_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic        clk_100_i,
    input  logic        rst_i,
    input  logic        cpu_ctrl_we_i,
    input  logic        cpu_data_we_i,
    input  logic        cpu_data_re_i,
    input  logic [7:0]  cpu_wdata_i,
    output logic [7:0]  cpu_rdata_o,
    output logic        cpu_busy_o,
    output logic        cpu_overrun_o,
    output logic        reg_we_o,
    output logic [3:0]  reg_num_o,
    output logic [7:0]  reg_data_o,
    output logic        cram_we_o,
    output logic [4:0]  cram_addr_o,
    output logic [7:0]  cram_data_o,
    output logic        slot_start_o,
    output logic        vram_go_o,
    output logic [13:0] vram_addr_o,
    output logic        vram_we_o,
    output logic        vram_re_o,
    output logic [7:0]  vram_wdata_o,
    input  logic [7:0]  vram_rdata_i
);
    logic slot0, rd_cap;

    vdp_slot_timer #(.SLOT_LEN(SLOT_LEN), .RD_LAT(RD_LAT)) u_timer (
        .clk_i       (clk_100_i),
        .rst_i       (rst_i),
        .slot_start_o(slot0),
        .rd_cap_o    (rd_cap)
    );

    logic [13:0] addr_q, addr_d, paddr_q, paddr_d;
    code_e       code_q, code_d;
    pend_e       pend_q, pend_d;
    logic        flag_q, flag_d, issued_q, issued_d;
    logic [7:0]  rbuf_q, rbuf_d, pdata_q, pdata_d;
    logic        reg_we_q, reg_we_d, cram_we_q, cram_we_d, ovr_q, ovr_d;
    logic [3:0]  reg_num_q, reg_num_d;
    logic [7:0]  reg_data_q, reg_data_d, cram_data_q, cram_data_d;
    logic [4:0]  cram_addr_q, cram_addr_d;
    logic [1:0]  nstb;
    logic        busy;

    assign busy = (pend_q != P_NONE);
    assign nstb = {1'b0, cpu_ctrl_we_i} + {1'b0, cpu_data_we_i} + {1'b0, cpu_data_re_i};

    always_comb begin
        addr_d      = addr_q;
        code_d      = code_q;
        flag_d      = flag_q;
        rbuf_d      = rbuf_q;
        pend_d      = pend_q;
        issued_d    = issued_q;
        paddr_d     = paddr_q;
        pdata_d     = pdata_q;
        reg_we_d    = 1'b0;
        reg_num_d   = reg_num_q;
        reg_data_d  = reg_data_q;
        cram_we_d   = 1'b0;
        cram_addr_d = cram_addr_q;
        cram_data_d = cram_data_q;
        ovr_d       = (nstb > 2'd1) || (busy && nstb != 2'd0);

        if (slot0 && pend_q == P_WR) pend_d = P_NONE;
        if (slot0 && pend_q == P_RD) issued_d = 1'b1;
        // issued_q keeps a read scheduled just before cycle RD_LAT from capturing stale data.
        if (rd_cap && issued_q) begin
            rbuf_d   = vram_rdata_i;
            pend_d   = P_NONE;
            issued_d = 1'b0;
        end

        if (!busy) begin
            if (cpu_ctrl_we_i) begin
                if (!flag_q) begin
                    addr_d[7:0] = cpu_wdata_i;
                    flag_d      = 1'b1;
                end else begin
                    flag_d = 1'b0;
                    code_d = code_e'(cpu_wdata_i[7:6]);
                    addr_d = {cpu_wdata_i[5:0], addr_q[7:0]};
                    case (code_e'(cpu_wdata_i[7:6]))
                        CODE_VRD: begin
                            pend_d  = P_RD;
                            paddr_d = addr_d;
                            addr_d  = addr_d + 14'd1;
                        end
                        CODE_REG: begin
                            reg_we_d   = 1'b1;
                            reg_num_d  = cpu_wdata_i[3:0];
                            reg_data_d = addr_q[7:0];
                        end
                        default: ;
                    endcase
                end
            end else if (cpu_data_we_i) begin
                flag_d = 1'b0;
                addr_d = addr_q + 14'd1;
                if (code_q == CODE_CRAM) begin
                    cram_we_d   = 1'b1;
                    cram_addr_d = addr_q[4:0];
                    cram_data_d = cpu_wdata_i;
                end else begin
                    pend_d  = P_WR;
                    paddr_d = addr_q;
                    pdata_d = cpu_wdata_i;
                    rbuf_d  = cpu_wdata_i;
                end
            end else if (cpu_data_re_i) begin
                flag_d  = 1'b0;
                pend_d  = P_RD;
                paddr_d = addr_q;
                addr_d  = addr_q + 14'd1;
            end
        end
    end

    always_ff @(posedge clk_100_i) begin
        if (rst_i) begin
            addr_q      <= '0;
            code_q      <= CODE_VRD;
            flag_q      <= 1'b0;
            rbuf_q      <= '0;
            pend_q      <= P_NONE;
            issued_q    <= 1'b0;
            paddr_q     <= '0;
            pdata_q     <= '0;
            reg_we_q    <= 1'b0;
            reg_num_q   <= '0;
            reg_data_q  <= '0;
            cram_we_q   <= 1'b0;
            cram_addr_q <= '0;
            cram_data_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            code_q      <= code_d;
            flag_q      <= flag_d;
            rbuf_q      <= rbuf_d;
            pend_q      <= pend_d;
            issued_q    <= issued_d;
            paddr_q     <= paddr_d;
            pdata_q     <= pdata_d;
            reg_we_q    <= reg_we_d;
            reg_num_q   <= reg_num_d;
            reg_data_q  <= reg_data_d;
            cram_we_q   <= cram_we_d;
            cram_addr_q <= cram_addr_d;
            cram_data_q <= cram_data_d;
            ovr_q       <= ovr_d;
        end
    end

    assign cpu_rdata_o   = rbuf_q;
    assign cpu_busy_o    = busy;
    assign cpu_overrun_o = ovr_q;
    assign reg_we_o      = reg_we_q;
    assign reg_num_o     = reg_num_q;
    assign reg_data_o    = reg_data_q;
    assign cram_we_o     = cram_we_q;
    assign cram_addr_o   = cram_addr_q;
    assign cram_data_o   = cram_data_q;
    assign slot_start_o  = slot0;
    assign vram_go_o     = slot0;
    assign vram_we_o     = slot0 && (pend_q == P_WR);
    assign vram_re_o     = slot0 && (pend_q == P_RD);
    assign vram_addr_o   = (vram_we_o || vram_re_o) ? paddr_q : 14'd0;
    assign vram_wdata_o  = vram_we_o ? pdata_q : 8'd0;
endmodule

// File: tb/tb_vdp_vram_sched.sv
// Bench for vdp_vram_sched: directed transaction table, corner sequences, and random traffic
// checked every cycle against a slot-arithmetic reference model.
module tb_vdp_vram_sched;
    localparam int SL = 8;
    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ctrl = 1'b0, dw = 1'b0, dr = 1'b0;
    logic [7:0]  wd = 8'h00, vrd = 8'h00;
    logic [7:0]  cpu_rdata, reg_data, cram_data, vram_wdata;
    logic        cpu_busy, cpu_overrun, reg_we, cram_we, slot_start, vram_go, vram_we, vram_re;
    logic [3:0]  reg_num;
    logic [4:0]  cram_addr;
    logic [13:0] vram_addr;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    vdp_vram_sched #(.SLOT_LEN(SL), .RD_LAT(RL)) dut (
        .clk_100_i    (clk),
        .rst_i        (rst),
        .cpu_ctrl_we_i(ctrl),
        .cpu_data_we_i(dw),
        .cpu_data_re_i(dr),
        .cpu_wdata_i  (wd),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_busy_o   (cpu_busy),
        .cpu_overrun_o(cpu_overrun),
        .reg_we_o     (reg_we),
        .reg_num_o    (reg_num),
        .reg_data_o   (reg_data),
        .cram_we_o    (cram_we),
        .cram_addr_o  (cram_addr),
        .cram_data_o  (cram_data),
        .slot_start_o (slot_start),
        .vram_go_o    (vram_go),
        .vram_addr_o  (vram_addr),
        .vram_we_o    (vram_we),
        .vram_re_o    (vram_re),
        .vram_wdata_o (vram_wdata),
        .vram_rdata_i (vrd)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is the cycle number n since reset release; slot boundaries are multiples of SL.
    int          n, m_exec, m_done;
    logic [13:0] m_addr, m_pa;
    logic [1:0]  m_code;
    logic        m_flag, m_rd, rst_s;
    logic [7:0]  m_first, m_buf, m_pd;
    logic        e_reg, e_cram, e_ovr;
    logic [3:0]  e_rn;
    logic [7:0]  e_rdat, e_cd;
    logic [4:0]  e_ca;

    task automatic m_acc(input logic rd, input logic [7:0] d);
        m_rd   = rd;
        m_pa   = m_addr;
        m_pd   = d;
        m_exec = (n / SL + 1) * SL;
        m_done = m_exec + 1 + (rd ? RL : 0);
        m_addr = m_addr + 14'd1;
    endtask

    always @(posedge clk) rst_s <= rst;

    always @(negedge clk) begin
        logic mb, mex;
        int   ns;
        if (rst) begin
            if (rst_s === 1'b1) begin
                chk("reset_ctl", {slot_start, vram_go, vram_we, vram_re, cpu_busy, cpu_overrun,
                                  reg_we, cram_we, vram_addr}, 0);
                chk("reset_dat", {cpu_rdata, vram_wdata, reg_data, cram_data}, 0);
                chk("reset_idx", {reg_num, cram_addr}, 0);
            end
            n = 0; m_exec = 0; m_done = 0; m_addr = '0; m_pa = '0; m_code = '0;
            m_flag = 1'b0; m_rd = 1'b0; m_first = '0; m_buf = '0; m_pd = '0;
            e_reg = 1'b0; e_cram = 1'b0; e_ovr = 1'b0; e_rn = '0; e_rdat = '0; e_cd = '0; e_ca = '0;
        end else begin
            mb  = (n < m_done);
            mex = mb && (n == m_exec);
            chk("slot_start", slot_start, (n % SL) == 0);
            chk("vram_go", vram_go, (n % SL) == 0);
            chk("vram_we", vram_we, mex && !m_rd);
            chk("vram_re", vram_re, mex && m_rd);
            chk("vram_addr", vram_addr, mex ? m_pa : 14'd0);
            chk("vram_wdata", vram_wdata, (mex && !m_rd) ? m_pd : 8'd0);
            chk("cpu_busy", cpu_busy, mb);
            chk("cpu_rdata", cpu_rdata, m_buf);
            chk("cpu_overrun", cpu_overrun, e_ovr);
            chk("reg_we", reg_we, e_reg);
            if (e_reg) chk("reg_num_data", {reg_num, reg_data}, {e_rn, e_rdat});
            chk("cram_we", cram_we, e_cram);
            if (e_cram) chk("cram_addr_data", {cram_addr, cram_data}, {e_ca, e_cd});

            if (mb && m_rd && n == m_exec + RL) m_buf = vrd;
            ns     = int'(ctrl) + int'(dw) + int'(dr);
            e_ovr  = (ns > 1) || (ns > 0 && mb);
            e_reg  = 1'b0;
            e_cram = 1'b0;
            if (!mb) begin
                if (ctrl) begin
                    if (!m_flag) begin
                        m_first = wd; m_addr[7:0] = wd; m_flag = 1'b1;
                    end else begin
                        m_flag = 1'b0; m_code = wd[7:6]; m_addr[13:8] = wd[5:0];
                        if (wd[7:6] == 2'd0) m_acc(1'b1, 8'h00);
                        else if (wd[7:6] == 2'd2) begin
                            e_reg = 1'b1; e_rn = wd[3:0]; e_rdat = m_first;
                        end
                    end
                end else if (dw) begin
                    m_flag = 1'b0;
                    if (m_code == 2'd3) begin
                        e_cram = 1'b1; e_ca = m_addr[4:0]; e_cd = wd; m_addr = m_addr + 14'd1;
                    end else begin
                        m_acc(1'b0, wd); m_buf = wd;
                    end
                end else if (dr) begin
                    m_flag = 1'b0; m_acc(1'b1, 8'h00);
                end
            end
            n++;
        end
    end

    // ---------------- directed helpers ----------------
    task automatic strobe(input logic c, input logic w, input logic r, input logic [7:0] d);
        ctrl = c; dw = w; dr = r; wd = d;
        @(posedge clk); #1;
        ctrl = 1'b0; dw = 1'b0; dr = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (cpu_busy && k < 30) begin
            @(posedge clk); #1; k++;
        end
        chk("idle_timeout", cpu_busy, 0);
    endtask

    task automatic watch(output int nwe, output int nre, output int nreg, output int ncram,
                         output int novr, output int nbusy, output logic [13:0] a, output logic [7:0] d);
        nwe = 0; nre = 0; nreg = 0; ncram = 0; novr = 0; nbusy = 0; a = '0; d = '0;
        for (int k = 0; k < SL + RL + 1; k++) begin
            @(negedge clk);
            if (vram_we)     begin nwe++;   a = vram_addr;       d = vram_wdata; end
            if (vram_re)     begin nre++;   a = vram_addr;                       end
            if (reg_we)      begin nreg++;  a = 14'(reg_num);    d = reg_data;   end
            if (cram_we)     begin ncram++; a = 14'(cram_addr);  d = cram_data;  end
            if (cpu_overrun) novr++;
            if (cpu_busy)    nbusy++;
        end
        @(posedge clk); #1;
    endtask

    // op: 1 ctrl, 2 data write, 3 data read. ev: 0 none, 1 vram wr, 2 vram rd, 3 reg, 4 cram.
    typedef struct {
        logic [1:0]  op;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [2:0]  ev;
        logic [13:0] ea;
        logic [7:0]  ed;
        logic [7:0]  ebuf;
    } vec_t;

    initial begin
        vec_t        tv[16];
        int          nwe, nre, nreg, ncram, novr, nbusy;
        logic [13:0] a;
        logic [7:0]  d;
        logic [15:0] exp_kind;
        logic        found;

        tv[0]  = '{2'd1, 8'h34, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h00};
        tv[1]  = '{2'd1, 8'h52, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h00};
        tv[2]  = '{2'd2, 8'hAB, 8'h00, 3'd1, 14'h1234, 8'hAB, 8'hAB};
        tv[3]  = '{2'd3, 8'h00, 8'hC3, 3'd2, 14'h1235, 8'h00, 8'hC3};
        tv[4]  = '{2'd1, 8'hFF, 8'h00, 3'd0, 14'h0000, 8'h00, 8'hC3};
        tv[5]  = '{2'd1, 8'h3F, 8'h5A, 3'd2, 14'h3FFF, 8'h00, 8'h5A};
        tv[6]  = '{2'd3, 8'h00, 8'h77, 3'd2, 14'h0000, 8'h00, 8'h77};
        tv[7]  = '{2'd1, 8'h07, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h77};
        tv[8]  = '{2'd1, 8'h85, 8'h00, 3'd3, 14'h0005, 8'h07, 8'h77};
        tv[9]  = '{2'd1, 8'h10, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h77};
        tv[10] = '{2'd1, 8'hC0, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h77};
        tv[11] = '{2'd2, 8'h3C, 8'h00, 3'd4, 14'h0010, 8'h3C, 8'h77};
        tv[12] = '{2'd2, 8'h0F, 8'h00, 3'd4, 14'h0011, 8'h0F, 8'h77};
        tv[13] = '{2'd1, 8'h00, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h77};
        tv[14] = '{2'd1, 8'h40, 8'h00, 3'd0, 14'h0000, 8'h00, 8'h77};
        tv[15] = '{2'd2, 8'h11, 8'h00, 3'd1, 14'h0000, 8'h11, 8'h11};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            wait_idle();
            vrd = tv[i].rd;
            strobe(tv[i].op == 2'd1, tv[i].op == 2'd2, tv[i].op == 2'd3, tv[i].wd);
            watch(nwe, nre, nreg, ncram, novr, nbusy, a, d);
            case (tv[i].ev)
                3'd1:    exp_kind = 16'h1000;
                3'd2:    exp_kind = 16'h0100;
                3'd3:    exp_kind = 16'h0010;
                3'd4:    exp_kind = 16'h0001;
                default: exp_kind = 16'h0000;
            endcase
            chk($sformatf("vec%0d_kind", i), {4'(nwe), 4'(nre), 4'(nreg), 4'(ncram)}, exp_kind);
            if (tv[i].ev != 3'd0) chk($sformatf("vec%0d_addr", i), a, tv[i].ea);
            if (tv[i].ev != 3'd0 && tv[i].ev != 3'd2) chk($sformatf("vec%0d_data", i), d, tv[i].ed);
            if (tv[i].ev == 3'd1 || tv[i].ev == 3'd2)
                chk($sformatf("vec%0d_busy_len", i), nbusy >= 1 && nbusy <= SL + RL, 1);
            else
                chk($sformatf("vec%0d_busy_len", i), nbusy, 0);
            chk($sformatf("vec%0d_overrun", i), novr, 0);
            chk($sformatf("vec%0d_rdata", i), cpu_rdata, tv[i].ebuf);
        end

        // second data write while busy is dropped; address advances once
        wait_idle();
        strobe(1'b1, 1'b0, 1'b0, 8'h00);
        strobe(1'b1, 1'b0, 1'b0, 8'h41);
        strobe(1'b0, 1'b1, 1'b0, 8'h55);
        strobe(1'b0, 1'b1, 1'b0, 8'h66);
        watch(nwe, nre, nreg, ncram, novr, nbusy, a, d);
        chk("ovr_writes", nwe, 1);
        chk("ovr_addr_data", {a, d}, {14'h0100, 8'h55});
        chk("ovr_pulses", novr, 1);
        wait_idle();
        vrd = 8'h21;
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        watch(nwe, nre, nreg, ncram, novr, nbusy, a, d);
        chk("ovr_next_addr", {4'(nre), a}, {4'd1, 14'h0101});

        // simultaneous strobes: control byte wins, the others are dropped
        wait_idle();
        strobe(1'b1, 1'b1, 1'b1, 8'h00);
        watch(nwe, nre, nreg, ncram, novr, nbusy, a, d);
        chk("multi_drop", {4'(nwe), 4'(nre), 4'(novr)}, {4'd0, 4'd0, 4'd1});
        strobe(1'b1, 1'b0, 1'b0, 8'h42);
        strobe(1'b0, 1'b1, 1'b0, 8'h99);
        watch(nwe, nre, nreg, ncram, novr, nbusy, a, d);
        chk("multi_ctrl_won", {4'(nwe), a, d}, {4'd1, 14'h0200, 8'h99});

        // reset lands on slot cycle 1 with a read in flight
        wait_idle();
        vrd = 8'hEE;
        strobe(1'b0, 1'b0, 1'b1, 8'h00);
        found = 1'b0;
        for (int k = 0; k < SL + 2; k++) begin
            @(negedge clk);
            if (vram_re) begin found = 1'b1; break; end
        end
        chk("rst_seq_re_seen", found, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_first_slot_start", slot_start, 1);
        chk("rst_busy", cpu_busy, 0);
        for (int k = 0; k < SL; k++) begin
            chk($sformatf("rst_no_capture_%0d", k), cpu_rdata, 8'h00);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            ctrl = ($urandom_range(0, 6) == 0);
            dw   = ($urandom_range(0, 6) == 0);
            dr   = ($urandom_range(0, 6) == 0);
            wd   = 8'($urandom);
            vrd  = 8'($urandom);
            rst  = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        ctrl = 1'b0; dw = 1'b0; dr = 1'b0; rst = 1'b0;
        repeat (SL + RL + 2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
